uart_rx_buffered: RTL

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

---
 rtl/uart_rx_buffered.sv | 309 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_buffered.sv
// Oversampled 8N1 UART receiver feeding a first-word fall-through byte FIFO.
// Define UART_RX_PARITY_EN to receive an even-parity bit between the data and stop bits.
`timescale 1ns/1ps
module uart_rx_buffered #(
  parameter int DEPTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   baud_tick,
  input  logic                   uart_rx,
  input  logic                   rd_en,
  input  logic                   err_clr,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   byte_done,
  output logic                   overrun,
  output logic                   frame_err,
  output logic                   parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity: the transmitted parity bit makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, rx_s;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_done_q, byte_done_d;
  logic            tick_half_s, tick_full_s, stop_sample_s, push_s, frame_set_s;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_s, pop_s, wr_s, overrun_set_s;
  logic            overrun_q, overrun_d, frame_err_q, frame_err_d;

`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d, parity_set_s;
  logic            parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s        = sync2_q;
  assign tick_half_s = baud_tick && (tick_cnt_q == HALF_LAST);
  assign tick_full_s = baud_tick && (tick_cnt_q == FULL_LAST);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
        else       state_d = S_IDLE;
      end
      S_START: begin
        if (tick_half_s) state_d = rx_s ? S_IDLE : S_DATA;
        else             state_d = S_START;
      end
      S_DATA: begin
        if (tick_full_s && (bit_cnt_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick_full_s) state_d = S_STOP;
        else             state_d = S_PARITY;
      end
`endif
      S_STOP: begin
        if (tick_full_s) state_d = S_IDLE;
        else             state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state datapath: tick counting, bit sampling and stop-bit evaluation.
  always_comb begin
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    stop_sample_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_set_s  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        tick_cnt_d = {TW{1'b0}};
        bit_cnt_d  = 3'd0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = 1'b0;
`endif
      end
      S_START: begin
        if (tick_half_s)    tick_cnt_d = {TW{1'b0}};
        else if (baud_tick) tick_cnt_d = tick_cnt_q + TW'(1);
        else                tick_cnt_d = tick_cnt_q;
      end
      S_DATA: begin
        if (tick_full_s) begin
          tick_cnt_d = {TW{1'b0}};
          shift_d    = {rx_s, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick_full_s) begin
          tick_cnt_d   = {TW{1'b0}};
          par_bad_d    = rx_s ^ even_parity(shift_q);
          parity_set_s = rx_s ^ even_parity(shift_q);
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
`endif
      S_STOP: begin
        if (tick_full_s) begin
          tick_cnt_d    = {TW{1'b0}};
          stop_sample_s = 1'b1;
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      default: begin
        tick_cnt_d = {TW{1'b0}};
        bit_cnt_d  = 3'd0;
      end
    endcase
  end

  assign frame_set_s = stop_sample_s && !rx_s;
`ifdef UART_RX_PARITY_EN
  assign push_s      = stop_sample_s && rx_s && !par_bad_q;
`else
  assign push_s      = stop_sample_s && rx_s;
`endif
  assign byte_done_d = push_s;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q  <= {TW{1'b0}};
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_done_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
`endif
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
`endif
    end
  end

  // A pop frees the slot, so a push into a full FIFO alongside a pop is accepted.
  assign full_s        = (count_q == DEPTH_C);
  assign pop_s         = rd_en && (count_q != {CW{1'b0}});
  assign wr_s          = push_s && (!full_s || pop_s);
  assign overrun_set_s = push_s && full_s && !pop_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_s) wr_ptr_d = wr_ptr_q + AW'(1);
    else      wr_ptr_d = wr_ptr_q;
    if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1);
    else       rd_ptr_d = rd_ptr_q;
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array needs no reset; only entries below count are ever read.
  always_ff @(posedge sysclk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // Sticky error flags: a same-cycle set takes priority over err_clr.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (overrun_set_s) overrun_d = 1'b1;
    else if (err_clr)  overrun_d = 1'b0;
    else               overrun_d = overrun_q;
    if (frame_set_s)   frame_err_d = 1'b1;
    else if (err_clr)  frame_err_d = 1'b0;
    else               frame_err_d = frame_err_q;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_comb begin
    parity_err_d = parity_err_q;
    if (parity_set_s) parity_err_d = 1'b1;
    else if (err_clr) parity_err_d = 1'b0;
    else              parity_err_d = parity_err_q;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rd_data   = mem_q[rd_ptr_q];
  assign empty     = (count_q == {CW{1'b0}});
  assign full      = full_s;
  assign count     = count_q;
  assign byte_done = byte_done_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
